// File: rtl/main_mem_responder_if.sv
// Main-memory bus between the cache/TLB CPU (master) and the memory
// responder (slave). Clock and reset are carried as plain ports alongside.
interface main_mem_responder_if;
    logic [31:0] mem_a;
    logic [31:0] mem_st_data;
    logic        mem_access;
    logic        mem_write;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        mem_busy;

    modport master (
        output mem_a,
        output mem_st_data,
        output mem_access,
        output mem_write,
        input  mem_data,
        input  mem_ready,
        input  mem_busy
    );

    modport slave (
        input  mem_a,
        input  mem_st_data,
        input  mem_access,
        input  mem_write,
        output mem_data,
        output mem_ready,
        output mem_busy
    );
endinterface

// File: rtl/main_mem_responder.sv
// Main-memory responder: word-addressed RAM serving one read or write at a
// time with a fixed LATENCY, finishing each transaction with a one-cycle
// mem_ready pulse followed by a one-cycle GAP so a held request is not
// accepted twice.
//
// Optional build macro MAIN_MEM_STATS_EN adds rd_count / wr_count ports that
// count completed reads and writes (16-bit, wrapping, cleared by clrn).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for mem_access; request latched on accept
// BUSY  | latency down-counter running; RAM accessed on its final edge
// READY | mem_ready high for this single cycle
// GAP   | mem_access ignored for one cycle, then back to IDLE
module main_mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 4     // 1..15 edges from accept to mem_ready
) (
    input  logic                 clk,
    input  logic                 clrn,
    main_mem_responder_if.slave  bus
`ifdef MAIN_MEM_STATS_EN
    ,
    output logic [15:0]          rd_count,
    output logic [15:0]          wr_count
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        READY = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [3:0]              cnt;
    logic [3:0]              cnt_nxt;
    logic                    accept;
    logic                    complete;

    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [31:0]             data_q;
    logic                    write_q;

    logic [31:0]             ram [2**ADDR_WIDTH];

    // Byte offset and high address bits play no part; high bits alias.
    logic                    unused_addr_bits;
    assign unused_addr_bits = ^{bus.mem_a[31:ADDR_WIDTH+2], bus.mem_a[1:0]};

    // State register and latency down-counter.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic; complete marks the BUSY->READY edge where RAM is touched.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.mem_access) begin
                    accept    = 1'b1;
                    cnt_nxt   = CNT_LOAD;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    complete  = 1'b1;
                    state_nxt = READY;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            READY:   state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture on accept, so later bus changes cannot disturb it.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            idx_q   <= '0;
            data_q  <= 32'd0;
            write_q <= 1'b0;
        end else if (accept) begin
            idx_q   <= bus.mem_a[ADDR_WIDTH+1:2];
            data_q  <= bus.mem_st_data;
            write_q <= bus.mem_write;
        end
    end

    // RAM write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (complete && write_q) begin
            ram[idx_q] <= data_q;
        end
    end

    // Registered read data, only updated when a read completes.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            bus.mem_data <= 32'd0;
        end else if (complete && !write_q) begin
            bus.mem_data <= ram[idx_q];
        end
    end

    assign bus.mem_ready = (state == READY);
    assign bus.mem_busy  = (state != IDLE);

`ifdef MAIN_MEM_STATS_EN
    // Completed-transaction counters; aborted transactions never reach complete.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rd_count <= 16'd0;
            wr_count <= 16'd0;
        end else if (complete) begin
            if (write_q) begin
                wr_count <= wr_count + 16'd1;
            end else begin
                rd_count <= rd_count + 16'd1;
            end
        end
    end
`endif

endmodule
